// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared state type, default widths and index helper for the PIO bus arbiter
package pio_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
  function automatic int wrap_add(int base, int off, int n);
    return base + off >= n ? base + off - n : base + off;
  endfunction
endpackage

// File: rtl/pio_bus_arbiter_if.sv
// pio_bus_arbiter_if: requester-side handshake plus Avalon-MM PIO slave bus
interface pio_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ-1:0] req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0] req_grant;
  logic [NUM_REQ-1:0] resp_valid;
  logic [DATA_W-1:0] resp_readdata;
  logic av_reset_n;
  logic av_chipselect;
  logic av_write_n;
  logic [ADDR_W-1:0] av_address;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W-1:0] av_readdata;
  modport master (
    output req_valid, req_write, req_lock, req_address, req_writedata,
    input req_grant, resp_valid, resp_readdata
  );
  modport slave (
    input req_valid, req_write, req_lock, req_address, req_writedata, av_readdata,
    output req_grant, resp_valid, resp_readdata,
    output av_reset_n, av_chipselect, av_write_n, av_address, av_writedata
  );
  modport pio (
    input av_reset_n, av_chipselect, av_write_n, av_address, av_writedata,
    output av_readdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting at ptr, restricted to mask
module rr_arbiter import pio_arb_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] elig;
  assign elig = req & mask;
  assign any = |elig;
  assign gnt = any ? N'(1) << idx : '0;
  // scan farthest-first so the nearest eligible slot after ptr is written last
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (elig[wrap_add(int'(ptr), k, N)]) idx = IW'(wrap_add(int'(ptr), k, N));
  end
endmodule

// File: rtl/pio_bus_arbiter.sv
// pio_bus_arbiter: round-robin sharing of one Avalon-MM PIO slave with optional bus lock
module pio_bus_arbiter import pio_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic reset,
  pio_bus_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  arb_state_e state;
  logic [IW-1:0] rr_ptr, owner, cur, win_idx;
  logic locked, lat_lock, hold, win_any;
  logic [NUM_REQ-1:0] elig_mask, win;
  assign bus.av_reset_n = ~reset;
  assign hold = locked && bus.req_lock[owner];
  assign elig_mask = hold ? NUM_REQ'(1) << owner : '1;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(bus.req_valid), .ptr(rr_ptr), .mask(elig_mask),
    .gnt(win), .idx(win_idx), .any(win_any)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cur <= '0;
      locked <= 1'b0;
      lat_lock <= 1'b0;
      bus.req_grant <= '0;
      bus.resp_valid <= '0;
      bus.resp_readdata <= '0;
      bus.av_chipselect <= 1'b0;
      bus.av_write_n <= 1'b1;
      bus.av_address <= '0;
      bus.av_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hold) locked <= 1'b0;
          if (win_any) begin
            cur <= win_idx;
            lat_lock <= bus.req_lock[win_idx];
            bus.req_grant <= win;
            bus.av_chipselect <= 1'b1;
            bus.av_write_n <= ~bus.req_write[win_idx];
            bus.av_address <= bus.req_address[win_idx*ADDR_W +: ADDR_W];
            bus.av_writedata <= bus.req_writedata[win_idx*DATA_W +: DATA_W];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.av_write_n) bus.resp_readdata <= bus.av_readdata;
          bus.req_grant <= '0;
          bus.resp_valid <= NUM_REQ'(1) << cur;
          bus.av_chipselect <= 1'b0;
          bus.av_write_n <= 1'b1;
          rr_ptr <= cur == IW'(NUM_REQ - 1) ? '0 : cur + 1'b1;
          locked <= lat_lock;
          owner <= cur;
          state <= RESP;
        end
        RESP: begin
          bus.resp_valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_bus_arbiter.sv
// tb_pio_bus_arbiter: directed + random stimulus, transaction-level model and scoreboard
module tb_pio_bus_arbiter;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  pio_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32)) bus ();
  pio_bus_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  // PIO slave: data register at address 0, other addresses read as zero
  logic [31:0] out_port;
  always_ff @(posedge clk)
    if (!bus.av_reset_n) out_port <= '0;
    else if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 2'd0) out_port <= bus.av_writedata;
  assign bus.av_readdata = bus.av_address == 2'd0 ? out_port : '0;

  typedef struct {int cyc; int idx; bit wr; logic [1:0] ad; logic [31:0] wd; logic [31:0] rd;} txn_t;
  txn_t gq[$], rq[$];
  int total = 0, bad = 0, cyc = 0;
  logic [3:0] pend = '0, wr = '0, lk = '0;
  logic [1:0] ad[4];
  logic [31:0] wd[4];
  int m_ptr = 0, m_owner = 0, busy = 0;
  bit m_locked = 0;
  logic [31:0] m_out = '0, m_rd = '0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.req_valid = pend;
    bus.req_write = wr;
    bus.req_lock = lk;
    for (int i = 0; i < 4; i++) begin
      bus.req_address[i*2 +: 2] = ad[i];
      bus.req_writedata[i*32 +: 32] = wd[i];
    end
  endtask

  // reference: one decision per idle slot, winner is first pending from m_ptr among eligible
  task automatic decide();
    int w;
    txn_t t;
    w = -1;
    if (m_locked && !lk[m_owner]) m_locked = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (w < 0 && pend[j] && (!m_locked || j == m_owner)) w = j;
    end
    if (w < 0) return;
    t.idx = w; t.wr = wr[w]; t.ad = ad[w]; t.wd = wd[w];
    if (t.wr) begin
      if (t.ad == 2'd0) m_out = t.wd;
    end else m_rd = t.ad == 2'd0 ? m_out : 32'd0;
    t.rd = m_rd;
    t.cyc = cyc + 1; gq.push_back(t);
    t.cyc = cyc + 2; rq.push_back(t);
    m_ptr = (w + 1) % 4; m_locked = lk[w]; m_owner = w;
    busy = 2; pend[w] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    reset = 0;
    drive();
    if (busy > 0) busy--;
    else decide();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    drive();
    gq.delete(); rq.delete();
    m_ptr = 0; m_owner = 0; m_locked = 0; busy = 0; m_out = '0; m_rd = '0;
  endtask

  task automatic req(int i, bit w, logic [1:0] a, logic [31:0] d, bit l);
    pend[i] = 1; wr[i] = w; ad[i] = a; wd[i] = d; lk[i] = l;
  endtask

  initial begin
    txn_t g, r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (|bus.req_grant) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'(bus.req_grant), 0);
        else begin
          g = gq.pop_front();
          chk("grant", 32'(bus.req_grant), 32'(1 << g.idx));
          chk("grant_cycle", cyc, g.cyc);
          chk("av_chipselect", 32'(bus.av_chipselect), 1);
          chk("av_write_n", 32'(bus.av_write_n), 32'(!g.wr));
          chk("av_address", 32'(bus.av_address), 32'(g.ad));
          if (g.wr) chk("av_writedata", bus.av_writedata, g.wd);
        end
      end else begin
        chk("idle_chipselect", 32'(bus.av_chipselect), 0);
        if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          chk("grant_missing", 32'(bus.req_grant), 32'(1 << gq[0].idx));
          void'(gq.pop_front());
        end
      end
      if (|bus.resp_valid) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'(bus.resp_valid), 0);
        else begin
          r = rq.pop_front();
          chk("resp_valid", 32'(bus.resp_valid), 32'(1 << r.idx));
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_readdata", bus.resp_readdata, r.rd);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        chk("resp_missing", 32'(bus.resp_valid), 32'(1 << rq[0].idx));
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin ad[i] = '0; wd[i] = '0; end
    drive();
    repeat (3) @(negedge clk);
    chk("rst_chipselect", 32'(bus.av_chipselect), 0);
    chk("rst_write_n", 32'(bus.av_write_n), 1);
    chk("rst_grant", 32'(bus.req_grant), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_readdata", bus.resp_readdata, 0);
    chk("rst_address", 32'(bus.av_address), 0);
    chk("rst_writedata", bus.av_writedata, 0);
    // single write, then read-backs of address 0 and 1
    req(0, 1, 2'd0, 32'hDEADBEEF, 0);
    repeat (4) step();
    chk("out_port", out_port, 32'hDEADBEEF);
    req(2, 0, 2'd0, 0, 0);
    repeat (3) step();
    req(2, 0, 2'd1, 0, 0);
    repeat (3) step();
    req(3, 0, 2'd2, 0, 0);
    repeat (3) step();
    // full contention from pointer 0
    for (int i = 0; i < 4; i++) req(i, 0, 2'(i), 0, 0);
    repeat (13) step();
    // lock: requester 1 keeps the bus ahead of waiting requester 3
    req(1, 1, 2'd0, 32'hA5A50001, 1);
    req(3, 0, 2'd0, 0, 0);
    repeat (6) step();
    req(1, 1, 2'd0, 32'hA5A50002, 1);
    repeat (3) step();
    lk[1] = 0;
    repeat (6) step();
    // reset clears a held lock
    req(1, 1, 2'd0, 32'h00000011, 1);
    repeat (3) step();
    req(0, 0, 2'd0, 0, 0);
    repeat (4) step();
    do_reset();
    repeat (4) step();
    lk[1] = 0;
    // reset while the write is on the bus
    req(0, 1, 2'd0, 32'hCAFEF00D, 0);
    step();
    do_reset();
    @(posedge clk);
    #2;
    chk("midrst_chipselect", 32'(bus.av_chipselect), 0);
    chk("midrst_write_n", 32'(bus.av_write_n), 1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 0);
    req(0, 0, 2'd0, 0, 0);
    repeat (4) step();
    // withdrawn one-cycle request while the bus is busy
    req(0, 1, 2'd1, 32'h5, 0);
    step();
    req(1, 1, 2'd0, 32'h77, 0);
    step();
    pend[1] = 0;
    repeat (6) step();
    chk("withdraw_out_port", out_port, 32'h0);
    repeat (1500) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(3) == 0)
          req(i, 1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, $urandom_range(5) == 0);
        else if (pend[i] && $urandom_range(30) == 0) pend[i] = 0;
        if (!pend[i] && lk[i] && $urandom_range(2) == 0) lk[i] = 0;
      end
      if ($urandom_range(399) == 0) do_reset();
      else step();
    end
    pend = '0;
    lk = '0;
    repeat (12) step();
    chk("queues_empty", 32'(gq.size() + rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pio_bus_arbiter.md
Name: pio_bus_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-MM PIO slave port (2-bit address, 32-bit data, chipselect/write_n, combinational readdata) between NUM_REQ requesters.
- Sits between CPU-side/peripheral requesters (ECU control tasks, debug bridge) and the PIO output register in the sys interconnect.
- Serialises transactions and returns read data to the issuing requester.
- Supports a bus lock so one requester can perform atomic read-modify-write sequences.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 2, slave address width.
- DATA_W, 32, slave data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending; held until granted.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  retain ownership after this transaction.
- req_address  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_writedata  in  NUM_REQ*DATA_W  flattened write data, sliced the same way.
- req_grant  out  NUM_REQ  one-hot, 1-cycle pulse; request accepted, requester may change inputs next cycle.
- resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse; transaction complete (reads and writes).
- resp_readdata  out  DATA_W  read data, valid with resp_valid; holds the last value otherwise.
- av_chipselect  out  1  to slave.
- av_write_n  out  1  to slave, active-low write.
- av_address  out  ADDR_W  to slave.
- av_writedata  out  DATA_W  to slave.
- av_readdata  in  DATA_W  from slave, combinational w.r.t. av_address.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high; ports named clk and reset.
  - The top level ties slave reset_n = ~reset.
- Reset values:
  - state = IDLE, rr_ptr = 0, locked = 0, owner = 0.
  - All outputs 0, except av_write_n = 1.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any eligible req_valid, select winner w, latch its write/address/writedata and req_lock, go to ISSUE. Otherwise stay.
  - Eligible set when unlocked: all i. Search order: rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - When locked and req_lock[owner] = 1: only owner is eligible; others wait, even if owner is idle.
  - When locked and req_lock[owner] = 0: clear locked and arbitrate normally in the same cycle.
- ISSUE (exactly 1 cycle):
  - av_chipselect = 1, av_write_n = ~latched write, av_address/av_writedata = latched values.
  - req_grant[w] = 1.
  - At the end of the cycle, capture av_readdata into resp_readdata (reads only; writes leave it unchanged).
  - Go to RESP.
- RESP (1 cycle):
  - av_chipselect = 0, av_write_n = 1, resp_valid[w] = 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - locked <= latched lock, owner <= w.
  - Go to IDLE.
- Latency: req_valid sampled in cycle 0 → grant and bus access in cycle 1 → resp_valid in cycle 2. Peak throughput is 1 transaction per 3 cycles.
- Simultaneous requests: exactly one grant per transaction. Other requesters keep req_valid high and are served in rotation. No starvation while unlocked: at most NUM_REQ-1 transactions of waiting.
- req_valid dropped before grant: request is withdrawn, no error.
- Lock is honoured indefinitely; starvation under lock is the software's responsibility.
- Reset asserted in ISSUE or RESP:
  - Return to IDLE next cycle.
  - No resp_valid pulse, lock cleared.
  - av_chipselect = 0 in the cycle after reset is sampled.
- Invariants:
  - av_chipselect is high for at most one consecutive cycle.
  - req_grant and resp_valid are zero or one-hot.

Decomposition:
- Shared package pio_arb_pkg: state enum (IDLE/ISSUE/RESP), default-width localparams.
- One sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: request vector, pointer, lock mask.
  - Outputs: one-hot winner and its index.
  - Reusable by other shared-peripheral arbiters in sys.

Test Plan:
- Single write: req 0 writes addr 0, data 0xDEADBEEF → cycle 1 shows av_chipselect=1, av_write_n=0, av_writedata=0xDEADBEEF; resp_valid=0001 in cycle 2; PIO out_port=0xDEADBEEF.
- Read-back: req 2 reads addr 0 after the previous write → resp_valid=0100, resp_readdata=0xDEADBEEF two cycles after request; a read of addr 1 returns 0x00000000.
- Contention: all four req_valid held high, rr_ptr=0 → grant order 0,1,2,3,0 with grants 3 cycles apart; each requester gets resp_valid exactly once per round.
- Lock: req 1 writes with req_lock=1 while req 3 is pending → req 1 is granted again ahead of req 3; req 1 drops req_lock → req 3 is granted next.
- Reset mid-transaction: assert reset during ISSUE → no resp_valid, av_chipselect=0 and av_write_n=1 the next cycle, rr_ptr=0, lock cleared; the next request from req 0 is served normally.
- Withdrawn request: req 1 pulses req_valid for 1 cycle while req 0 is busy → req 1 is never granted, and no spurious slave access occurs.
